jtag_ir_dr: RTL and testbench

Instruction-register and data-register datapath that sits directly downstream of the JTAG TAP controller and consumes its 4-bit state output. It runs the IR and DR shift chains and decodes the instruction. It drives the real TDO pin and exposes a user register to fabric logic. Register set: BYPASS, IDCODE, and a read/write USER1 register.

---
 rtl/jtag_pkg.sv | 37 +++
 rtl/jtag_ir_dec.sv | 17 +
 rtl/jtag_ir_dr.sv | 123 ++++++++++++
 tb/tb_jtag_ir_dr.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding (common with the TAP controller),
// instruction register width, opcodes and the instruction-select struct.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_TEST_LOGIC_RESET = 4'h0,
    TAP_RUN_TEST_IDLE    = 4'h1,
    TAP_SELECT_DR        = 4'h2,
    TAP_CAPTURE_DR       = 4'h3,
    TAP_SHIFT_DR         = 4'h4,
    TAP_EXIT1_DR         = 4'h5,
    TAP_PAUSE_DR         = 4'h6,
    TAP_EXIT2_DR         = 4'h7,
    TAP_UPDATE_DR        = 4'h8,
    TAP_SELECT_IR        = 4'h9,
    TAP_CAPTURE_IR       = 4'hA,
    TAP_SHIFT_IR         = 4'hB,
    TAP_EXIT1_IR         = 4'hC,
    TAP_PAUSE_IR         = 4'hD,
    TAP_EXIT2_IR         = 4'hE,
    TAP_UPDATE_IR        = 4'hF
  } tap_state_e;

  localparam int MXIR = 5;

  localparam logic [MXIR-1:0] OP_IDCODE = 5'h01;
  localparam logic [MXIR-1:0] OP_USER1  = 5'h02;
  localparam logic [MXIR-1:0] OP_BYPASS = 5'h1F;

  // One-hot data register select derived from the current instruction.
  typedef struct packed {
    logic idcode;
    logic user1;
    logic bypass;
  } ir_sel_t;

endpackage

// File: rtl/jtag_ir_dec.sv
// Combinational instruction decoder: current IR to one-hot data register select.
// Any opcode that is not IDCODE or USER1 (including undefined ones) selects BYPASS.
module jtag_ir_dec
  import jtag_pkg::*;
(
  input  logic [MXIR-1:0] ir_i,
  output ir_sel_t         sel_o
);

  always_comb begin
    sel_o        = '0;
    sel_o.idcode = (ir_i == OP_IDCODE);
    sel_o.user1  = (ir_i == OP_USER1);
    sel_o.bypass = !(sel_o.idcode || sel_o.user1);
  end

endmodule

// File: rtl/jtag_ir_dr.sv
// JTAG IR/DR datapath downstream of the TAP controller: shift chains capture and
// shift on posedge tck, instruction/user updates and TDO launch on negedge tck.
module jtag_ir_dr
  import jtag_pkg::*;
#(
  parameter int              MXDR       = 32,
  parameter logic [MXDR-1:0] IDCODE_VAL = 32'h0A00_0093
) (
  input  logic            tck,
  input  logic            ntrst,
  input  logic [3:0]      state,
  input  logic            tdi,
  input  logic [MXDR-1:0] user_rd,
  output logic            tdo,
  output logic            tdo_oe,
  output logic [MXIR-1:0] ir,
  output logic [MXDR-1:0] user_wr,
  output logic            user_wr_strb
);

  tap_state_e st;
  ir_sel_t    sel;

  logic [MXIR-1:0] ir_sr_q, ir_sr_d;
  logic [MXDR-1:0] dr_sr_q, dr_sr_d;
  logic            bypass_q, bypass_d;
  logic [MXIR-1:0] ir_q, ir_d;
  logic [MXDR-1:0] user_wr_q, user_wr_d;
  logic            strb_q, strb_d;
  logic            tdo_q, tdo_d;
  logic            tdo_oe_q, tdo_oe_d;

  assign st = tap_state_e'(state);

  jtag_ir_dec u_dec (
    .ir_i  (ir_q),
    .sel_o (sel)
  );

  // Posedge side: capture and shift, keyed on the state before the edge.
  always_comb begin
    ir_sr_d  = ir_sr_q;
    dr_sr_d  = dr_sr_q;
    bypass_d = bypass_q;
    case (st)
      TAP_CAPTURE_IR: ir_sr_d = {{(MXIR-2){1'b0}}, 2'b01};
      TAP_SHIFT_IR:   ir_sr_d = {tdi, ir_sr_q[MXIR-1:1]};
      TAP_CAPTURE_DR: begin
        if (sel.idcode)     dr_sr_d  = IDCODE_VAL;
        else if (sel.user1) dr_sr_d  = user_rd;
        else                bypass_d = 1'b0;
      end
      TAP_SHIFT_DR: begin
        if (sel.bypass) bypass_d = tdi;
        else            dr_sr_d  = {tdi, dr_sr_q[MXDR-1:1]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge tck or negedge ntrst) begin
    if (!ntrst) begin
      ir_sr_q  <= '0;
      dr_sr_q  <= '0;
      bypass_q <= 1'b0;
    end else begin
      ir_sr_q  <= ir_sr_d;
      dr_sr_q  <= dr_sr_d;
      bypass_q <= bypass_d;
    end
  end

  // Negedge side: strobe defaults low so any pulse lasts exactly one tck.
  always_comb begin
    ir_d      = ir_q;
    user_wr_d = user_wr_q;
    strb_d    = 1'b0;
    tdo_d     = tdo_q;
    tdo_oe_d  = 1'b0;
    case (st)
      TAP_TEST_LOGIC_RESET: ir_d = OP_IDCODE;
      TAP_UPDATE_IR:        ir_d = ir_sr_q;
      TAP_UPDATE_DR: begin
        if (sel.user1) begin
          user_wr_d = dr_sr_q;
          strb_d    = 1'b1;
        end
      end
      TAP_SHIFT_IR: begin
        tdo_oe_d = 1'b1;
        tdo_d    = ir_sr_q[0];
      end
      TAP_SHIFT_DR: begin
        tdo_oe_d = 1'b1;
        tdo_d    = sel.bypass ? bypass_q : dr_sr_q[0];
      end
      default: ;
    endcase
  end

  always_ff @(negedge tck or negedge ntrst) begin
    if (!ntrst) begin
      ir_q      <= OP_IDCODE;
      user_wr_q <= '0;
      strb_q    <= 1'b0;
      tdo_q     <= 1'b0;
      tdo_oe_q  <= 1'b0;
    end else begin
      ir_q      <= ir_d;
      user_wr_q <= user_wr_d;
      strb_q    <= strb_d;
      tdo_q     <= tdo_d;
      tdo_oe_q  <= tdo_oe_d;
    end
  end

  assign tdo          = tdo_q;
  assign tdo_oe       = tdo_oe_q;
  assign ir           = ir_q;
  assign user_wr      = user_wr_q;
  assign user_wr_strb = strb_q;

endmodule

// File: tb/tb_jtag_ir_dr.sv
// Bench for jtag_ir_dr: the TAP state is driven directly, one state per tck,
// with outputs sampled just after each negedge.
module tb_jtag_ir_dr;
  import jtag_pkg::*;

  logic        tck = 1'b0;
  logic        ntrst = 1'b1;
  logic [3:0]  state = TAP_TEST_LOGIC_RESET;
  logic        tdi = 1'b0;
  logic [31:0] user_rd = '0;
  logic        tdo;
  logic        tdo_oe;
  logic [4:0]  ir;
  logic [31:0] user_wr;
  logic        user_wr_strb;

  int n_checks = 0;
  int n_errors = 0;

  // Outputs sampled just after the negedge of the most recent step.
  logic        s_tdo, s_oe, s_strb;
  logic [4:0]  s_ir;
  logic [31:0] s_user_wr;

  typedef struct {
    logic [3:0] st;
    logic       d;
    logic       chk_tdo;
    logic       exp_tdo;
    logic       exp_oe;
    logic [4:0] exp_ir;
  } vec_t;

  typedef struct {
    logic [31:0] dout;
    logic [31:0] upd_wr;
    logic        pre_strb;
    logic        upd_strb;
    logic        post_strb;
    int          pause_oe_bad;
    int          shift_oe_bad;
  } dr_res_t;

  vec_t vecs[$];

  jtag_ir_dr dut (
    .tck          (tck),
    .ntrst        (ntrst),
    .state        (state),
    .tdi          (tdi),
    .user_rd      (user_rd),
    .tdo          (tdo),
    .tdo_oe       (tdo_oe),
    .ir           (ir),
    .user_wr      (user_wr),
    .user_wr_strb (user_wr_strb)
  );

  // Clock and watchdog
  always #5 tck = ~tck;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] s, input logic d);
    state = s;
    tdi   = d;
    @(negedge tck);
    #1;
    s_tdo     = tdo;
    s_oe      = tdo_oe;
    s_strb    = user_wr_strb;
    s_ir      = ir;
    s_user_wr = user_wr;
    @(posedge tck);
    #1;
  endtask

  task automatic ir_scan(input logic [4:0] val, output logic [4:0] cap);
    cap = '0;
    step(TAP_SELECT_DR, 1'b0);
    step(TAP_SELECT_IR, 1'b0);
    step(TAP_CAPTURE_IR, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(TAP_SHIFT_IR, val[i]);
      cap[i] = s_tdo;
    end
    step(TAP_EXIT1_IR, 1'b0);
    step(TAP_UPDATE_IR, 1'b0);
    step(TAP_RUN_TEST_IDLE, 1'b0);
  endtask

  task automatic dr_scan(input logic [31:0] din, input int n, input int pause_at,
                         output dr_res_t r);
    r = '{default: '0};
    step(TAP_SELECT_DR, 1'b0);
    step(TAP_CAPTURE_DR, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i == pause_at) begin
        step(TAP_EXIT1_DR, 1'b0);
        for (int k = 0; k < 3; k++) begin
          step(TAP_PAUSE_DR, 1'b1);
          if (s_oe) r.pause_oe_bad++;
        end
        step(TAP_EXIT2_DR, 1'b0);
      end
      step(TAP_SHIFT_DR, din[i]);
      r.dout[i] = s_tdo;
      if (!s_oe) r.shift_oe_bad++;
    end
    step(TAP_EXIT1_DR, 1'b0);
    r.pre_strb = s_strb;
    step(TAP_UPDATE_DR, 1'b0);
    r.upd_wr   = s_user_wr;
    r.upd_strb = s_strb;
    step(TAP_RUN_TEST_IDLE, 1'b0);
    r.post_strb = s_strb;
  endtask

  function automatic void add(input logic [3:0] st, input logic d, input logic chk,
                              input logic etdo, input logic eoe, input logic [4:0] eir);
    vecs.push_back('{st, d, chk, etdo, eoe, eir});
  endfunction

  // Stimulus and scoreboard
  initial begin
    dr_res_t    r;
    logic [4:0] cap;
    logic [8:0] byp;

    // IR scan of 0x1F then a 9-bit BYPASS scan of 0x0A5 (bit 8 flushes the last bit).
    add(TAP_RUN_TEST_IDLE, 0, 0, 0, 0, 5'h01);
    add(TAP_SELECT_DR,     0, 0, 0, 0, 5'h01);
    add(TAP_SELECT_IR,     0, 0, 0, 0, 5'h01);
    add(TAP_CAPTURE_IR,    0, 0, 0, 0, 5'h01);
    add(TAP_SHIFT_IR,      1, 1, 1, 1, 5'h01);
    add(TAP_SHIFT_IR,      1, 1, 0, 1, 5'h01);
    add(TAP_SHIFT_IR,      1, 1, 0, 1, 5'h01);
    add(TAP_SHIFT_IR,      1, 1, 0, 1, 5'h01);
    add(TAP_SHIFT_IR,      1, 1, 0, 1, 5'h01);
    add(TAP_EXIT1_IR,      0, 1, 0, 0, 5'h01);
    add(TAP_UPDATE_IR,     0, 1, 0, 0, 5'h1F);
    add(TAP_SELECT_DR,     0, 0, 0, 0, 5'h1F);
    add(TAP_CAPTURE_DR,    0, 0, 0, 0, 5'h1F);
    byp = 9'h0A5;
    for (int i = 0; i < 9; i++)
      add(TAP_SHIFT_DR, byp[i], 1, (i == 0) ? 1'b0 : byp[i-1], 1, 5'h1F);
    add(TAP_EXIT1_DR,      0, 1, 1, 0, 5'h1F);
    add(TAP_UPDATE_DR,     0, 1, 1, 0, 5'h1F);
    add(TAP_RUN_TEST_IDLE, 0, 1, 1, 0, 5'h1F);

    // Reset
    #1 ntrst = 1'b0;
    repeat (2) @(posedge tck);
    #3;
    check("rst_ir", 32'(ir), 32'h01);
    check("rst_tdo", 32'(tdo), 32'h0);
    check("rst_oe", 32'(tdo_oe), 32'h0);
    check("rst_user_wr", user_wr, 32'h0);
    check("rst_strb", 32'(user_wr_strb), 32'h0);
    @(posedge tck);
    #1 ntrst = 1'b1;
    step(TAP_TEST_LOGIC_RESET, 1'b0);
    check("tlr_ir", 32'(s_ir), 32'h01);

    // 1: IDCODE read after reset
    step(TAP_RUN_TEST_IDLE, 1'b0);
    dr_scan(32'h0, 32, -1, r);
    check("idcode_dout", r.dout, 32'h0A00_0093);
    check("idcode_ir", 32'(ir), 32'h01);
    check("idcode_shift_oe", 32'(r.shift_oe_bad), 32'd0);
    check("idcode_upd_strb", 32'(r.upd_strb), 32'h0);
    check("idcode_upd_wr", r.upd_wr, 32'h0);

    // 2: table-driven IR scan to BYPASS and one-bit-delay DR scan
    foreach (vecs[i]) begin
      step(vecs[i].st, vecs[i].d);
      check($sformatf("vec%0d_oe", i), 32'(s_oe), 32'(vecs[i].exp_oe));
      check($sformatf("vec%0d_ir", i), 32'(s_ir), 32'(vecs[i].exp_ir));
      if (vecs[i].chk_tdo)
        check($sformatf("vec%0d_tdo", i), 32'(s_tdo), 32'(vecs[i].exp_tdo));
    end

    // 3: USER1 read/write with strobe
    user_rd = 32'hDEAD_BEEF;
    ir_scan(5'h02, cap);
    check("user1_ir_cap", 32'(cap), 32'h01);
    check("user1_ir", 32'(ir), 32'h02);
    dr_scan(32'h1234_5678, 32, -1, r);
    check("user1_dout", r.dout, 32'hDEAD_BEEF);
    check("user1_pre_strb", 32'(r.pre_strb), 32'h0);
    check("user1_upd_wr", r.upd_wr, 32'h1234_5678);
    check("user1_upd_strb", 32'(r.upd_strb), 32'h1);
    check("user1_post_strb", 32'(r.post_strb), 32'h0);
    check("user1_wr_held", user_wr, 32'h1234_5678);

    // 4: USER1 scan with a pause after 10 bits
    user_rd = 32'hCAFE_F00D;
    dr_scan(32'h0BAD_C0DE, 32, 10, r);
    check("pause_dout", r.dout, 32'hCAFE_F00D);
    check("pause_upd_wr", r.upd_wr, 32'h0BAD_C0DE);
    check("pause_upd_strb", 32'(r.upd_strb), 32'h1);
    check("pause_oe", 32'(r.pause_oe_bad), 32'd0);
    check("pause_shift_oe", 32'(r.shift_oe_bad), 32'd0);

    // 5: ntrst mid-shift discards the scan
    user_rd = 32'hFFFF_FFFF;
    step(TAP_SELECT_DR, 1'b0);
    step(TAP_CAPTURE_DR, 1'b0);
    for (int i = 0; i < 10; i++) step(TAP_SHIFT_DR, 1'b1);
    check("midrst_pre_tdo", 32'(s_tdo), 32'h1);
    ntrst = 1'b0;
    #2;
    check("midrst_ir", 32'(ir), 32'h01);
    check("midrst_user_wr", user_wr, 32'h0);
    check("midrst_strb", 32'(user_wr_strb), 32'h0);
    check("midrst_tdo", 32'(tdo), 32'h0);
    check("midrst_oe", 32'(tdo_oe), 32'h0);
    step(TAP_TEST_LOGIC_RESET, 1'b0);
    ntrst = 1'b1;
    step(TAP_TEST_LOGIC_RESET, 1'b0);
    step(TAP_RUN_TEST_IDLE, 1'b0);
    check("midrst_after_strb", 32'(s_strb), 32'h0);
    check("midrst_after_wr", s_user_wr, 32'h0);
    check("midrst_after_ir", 32'(s_ir), 32'h01);

    // 6: undefined opcode acts as BYPASS, then TMS-high walk to reset
    ir_scan(5'h07, cap);
    check("undef_ir_cap", 32'(cap), 32'h01);
    check("undef_ir", 32'(ir), 32'h07);
    dr_scan(32'h0000_003C, 9, -1, r);
    check("undef_dout", r.dout, 32'h0000_0078);
    check("undef_upd_strb", 32'(r.upd_strb), 32'h0);
    check("undef_upd_wr", r.upd_wr, 32'h0);
    step(TAP_SELECT_DR, 1'b0);
    step(TAP_SELECT_IR, 1'b0);
    check("undef_ir_held", 32'(s_ir), 32'h07);
    step(TAP_TEST_LOGIC_RESET, 1'b0);
    check("tms_reset_ir", 32'(s_ir), 32'h01);
    step(TAP_TEST_LOGIC_RESET, 1'b0);
    step(TAP_TEST_LOGIC_RESET, 1'b0);
    check("tms_reset_ir_held", 32'(s_ir), 32'h01);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
